cambus_photon_tx: RTL and testbench
===================================

CAMBUS_PHOTON_TX -- requirements
Module: cambus_photon_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, clk cycles per DATA_CLK half-period (min 1).
REQ-002 SHALL have parameters H_ACTIVE=640, H_BLANK=32, V_ACTIVE=480, V_BLANK=20: pixel slots per line and lines per frame.
REQ-003 SHALL have parameters VSYNC_LINE=2, the blank-line index where vsync starts, and VSYNC_LEN=4, the vsync width in pixel slots.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk  in  1  system clock (50MHz); rst  in  1  reset.
REQ-005 en  in  1  frame enable, sampled only at frame start.
REQ-006 pat_en  in  1  select internal test pattern (see Configuration).
REQ-007 src_pixel  in  14  upstream pixel; src_valid  in  1  pixel available.
REQ-008 src_ready  out  1  one-clk pulse, pixel consumed.
REQ-009 cam_DATA_CLK  out  1  bus clock; receiver samples on falling edge.
REQ-010 cam_DATA_SYNC, cam_DATA1_OUT, cam_DATA2_OUT  out  1 each  serial lines.
REQ-011 frame_start  out  1  one-clk pulse at bit 1 of frame's first slot; underrun  out  1  sticky.

Function
REQ-012 cam_DATA_CLK SHALL toggle every CLK_DIV clk cycles, free-running whenever out of reset.
REQ-013 All serial lines SHALL change only in the clk cycle where cam_DATA_CLK goes 0->1, for CLK_DIV cycles of setup before the falling edge.
REQ-014 Each pixel slot SHALL be 7 bit periods (bits b1..b7); bit index wraps 7->1.
REQ-015 Sync per slot SHALL be b1=1, b2=1, b3=VS, b4=0, b5=HS, b6=0, b7=0, so 0,1,1 occurs only at slot start.
REQ-016 DATA1 SHALL carry pixel[6:0] and DATA2 pixel[13:7], MSB first, b1..b7.
REQ-017 HS SHALL be 1 for the first H_ACTIVE slots of each of the first V_ACTIVE lines and 0 elsewhere; data SHALL be 0 when HS=0.
REQ-018 VS SHALL be 1 for VSYNC_LEN consecutive slots starting at slot 0 of blank line VSYNC_LINE (line V_ACTIVE+VSYNC_LINE) and 0 otherwise.
REQ-019 Slot counter wraps at H_ACTIVE+H_BLANK; line counter wraps at V_ACTIVE+V_BLANK, then frame restarts.
REQ-020 The pixel SHALL be fetched in the clk cycle of b1's rising edge; if src_valid=1, src_ready pulses and src_pixel is latched.
REQ-021 If src_valid=0 at fetch of an active slot, the slot SHALL send pixel 0, src_ready SHALL stay 0, and underrun SHALL set.
REQ-022 src_ready SHALL never pulse in blank slots or while idle.
REQ-023 States: IDLE (sync/data 0, clock running), RUN; IDLE->RUN at a slot boundary when en=1; RUN->IDLE only at frame end when en=0.
REQ-024 en deasserted mid-frame SHALL NOT truncate the frame.
REQ-025 frame_start SHALL pulse at the same clk cycle as the fetch of line 0, slot 0.

Reset
REQ-026 rst SHALL force cam_DATA_CLK=0, all serial lines=0, src_ready=0, frame_start=0, underrun=0, state IDLE, counters 0.
REQ-027 The first rising edge of cam_DATA_CLK SHALL occur CLK_DIV cycles after rst deasserts.
REQ-028 rst asserted mid-slot SHALL abort immediately; no partial pixel is resumed.

Configuration
REQ-029 With CAMBUS_PHOTON_TX_PATTERN_EN defined, pat_en=1 SHALL send an internal 14-bit counter instead of the upstream pixel.
REQ-030 With the macro, the counter SHALL increment per active slot, wrap 16383->0, and reset to 0 at frame_start.
REQ-031 With the macro and pat_en=1, src_ready SHALL stay 0 and underrun SHALL NOT set.
REQ-032 Without the macro, pat_en SHALL be ignored and no counter logic exists.

Verification
REQ-033 Reset, en=1, src_valid=1, src_pixel=14'h2A55 -> DATA_CLK period 4 clk; first slot sync 1,1,0,0,1,0,0; DATA1 1010101; DATA2 1010100.
REQ-034 H_ACTIVE=4, H_BLANK=2, V_ACTIVE=2, V_BLANK=3 -> 4 src_ready pulses per active line; sync b5=0 in blank slots; frame repeats every 30 slots.
REQ-035 Same geometry with VSYNC_LINE=1, VSYNC_LEN=4 -> b3=1 in line 3 slots 0..3 only.
REQ-036 src_valid=0 for one active slot -> that slot's data is 0, no src_ready pulse, underrun=1 until rst.
REQ-037 en dropped mid-frame -> frame completes, then sync stays 0 with DATA_CLK still toggling; no 0,1,1 pattern appears.
REQ-038 Macro defined, pat_en=1 -> consecutive active pixels 0,1,2...; reference receiver reassembles identical values.

Source files
------------

// File: rtl/cambus_photon_tx.sv
// Camera-bus serial transmitter: 7-bit pixel slots carrying sync plus two 7-bit data lanes.
// Define CAMBUS_PHOTON_TX_PATTERN_EN to build the internal counting test-pattern source.
module cambus_photon_tx #(
  parameter int CLK_DIV    = 2,
  parameter int H_ACTIVE   = 640,
  parameter int H_BLANK    = 32,
  parameter int V_ACTIVE   = 480,
  parameter int V_BLANK    = 20,
  parameter int VSYNC_LINE = 2,
  parameter int VSYNC_LEN  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        pat_en,
  input  logic [13:0] src_pixel,
  input  logic        src_valid,
  output logic        src_ready,
  output logic        cam_DATA_CLK,
  output logic        cam_DATA_SYNC,
  output logic        cam_DATA1_OUT,
  output logic        cam_DATA2_OUT,
  output logic        frame_start,
  output logic        underrun
);

  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int V_TOTAL = V_ACTIVE + V_BLANK;
  localparam int SLOT_W  = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int LINE_W  = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(H_TOTAL - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(V_TOTAL - 1);
  localparam logic [31:0]       H_ACT_U   = H_ACTIVE;
  localparam logic [31:0]       V_ACT_U   = V_ACTIVE;
  localparam logic [31:0]       VS_LINE_U = V_ACTIVE + VSYNC_LINE;
  localparam logic [31:0]       VS_LEN_U  = VSYNC_LEN;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_nxt;
  logic [DIV_W-1:0]  div_cnt;
  logic              dclk;
  logic [2:0]        bit_cnt;
  logic [SLOT_W-1:0] slot_cnt;
  logic [LINE_W-1:0] line_cnt;
  logic              rise, slot_start, slot_end, at_origin;
  logic              sending, hs, vs;
  logic              take, miss, use_pat;
  logic [13:0]       pat_pix, pix_new, pix_q, cur_pix;
  logic              sync_nxt, d1_nxt, d2_nxt;

  // Sync word b1..b7 = 1,1,VS,0,HS,0,0 so 0,1,1 only ever appears across a slot boundary.
  function automatic logic sync_of(input logic [2:0] b, input logic v, input logic h);
    logic r;
    r = 1'b0;
    case (b)
      3'd1, 3'd2: r = 1'b1;
      3'd3:       r = v;
      3'd5:       r = h;
      default:    r = 1'b0;
    endcase
    return r;
  endfunction

  // Lanes go out MSB first: b1 carries bit 6, b7 carries bit 0.
  function automatic logic lane_bit(input logic [6:0] v, input logic [2:0] b);
    logic r;
    r = 1'b0;
    case (b)
      3'd1:    r = v[6];
      3'd2:    r = v[5];
      3'd3:    r = v[4];
      3'd4:    r = v[3];
      3'd5:    r = v[2];
      3'd6:    r = v[1];
      3'd7:    r = v[0];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Bus clock divider, free-running out of reset
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      dclk    <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      dclk    <= ~dclk;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign cam_DATA_CLK = dclk;
  assign rise         = (div_cnt == DIV_LAST) && !dclk;
  assign slot_start   = rise && (bit_cnt == 3'd1);
  assign slot_end     = rise && (bit_cnt == 3'd7);
  assign at_origin    = (slot_cnt == '0) && (line_cnt == '0);
  assign hs = (32'(slot_cnt) < H_ACT_U) && (32'(line_cnt) < V_ACT_U);
  assign vs = (32'(line_cnt) == VS_LINE_U) && (32'(slot_cnt) < VS_LEN_U);

  // Bit phase and slot/line position of the slot currently on the wire
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt  <= 3'd1;
      slot_cnt <= '0;
      line_cnt <= '0;
    end else if (rise) begin
      bit_cnt <= (bit_cnt == 3'd7) ? 3'd1 : bit_cnt + 3'd1;
      if (slot_end) begin
        if (state != RUN) begin
          slot_cnt <= '0;
          line_cnt <= '0;
        end else if (slot_cnt == SLOT_LAST) begin
          slot_cnt <= '0;
          line_cnt <= (line_cnt == LINE_LAST) ? '0 : line_cnt + LINE_W'(1);
        end else begin
          slot_cnt <= slot_cnt + SLOT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // en only matters at the frame origin, so a frame is never cut short
  always_comb begin
    state_nxt = state;
    if (slot_start && at_origin) state_nxt = en ? RUN : IDLE;
  end

  assign sending = (state_nxt == RUN);

`ifdef CAMBUS_PHOTON_TX_PATTERN_EN
  logic [13:0] pat_cnt;

  assign use_pat = pat_en;
  assign pat_pix = at_origin ? 14'd0 : pat_cnt;

  always_ff @(posedge clk) begin
    if (rst)                            pat_cnt <= '0;
    else if (slot_start && sending && hs) pat_cnt <= pat_pix + 14'd1;
  end
`else
  logic unused_pat_en;

  assign unused_pat_en = pat_en;
  assign use_pat       = 1'b0;
  assign pat_pix       = '0;
`endif

  // Pixel fetch happens on the b1 rising edge of an active slot only
  always_comb begin
    take    = 1'b0;
    miss    = 1'b0;
    pix_new = '0;
    if (slot_start && sending && hs) begin
      if (use_pat) begin
        pix_new = pat_pix;
      end else if (src_valid) begin
        take    = 1'b1;
        pix_new = src_pixel;
      end else begin
        miss    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (slot_start) pix_q <= pix_new;
  end

  assign cur_pix = slot_start ? pix_new : pix_q;

  always_comb begin
    sync_nxt = 1'b0;
    d1_nxt   = 1'b0;
    d2_nxt   = 1'b0;
    if (sending) begin
      sync_nxt = sync_of(bit_cnt, vs, hs);
      d1_nxt   = lane_bit(cur_pix[6:0], bit_cnt);
      d2_nxt   = lane_bit(cur_pix[13:7], bit_cnt);
    end
  end

  // Serial lines update only with the bus-clock rising edge
  always_ff @(posedge clk) begin
    if (rst) begin
      cam_DATA_SYNC <= 1'b0;
      cam_DATA1_OUT <= 1'b0;
      cam_DATA2_OUT <= 1'b0;
      src_ready     <= 1'b0;
      frame_start   <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      src_ready   <= take;
      frame_start <= slot_start && at_origin && sending;
      if (miss) underrun <= 1'b1;
      if (rise) begin
        cam_DATA_SYNC <= sync_nxt;
        cam_DATA1_OUT <= d1_nxt;
        cam_DATA2_OUT <= d2_nxt;
      end
    end
  end

endmodule

// File: tb/tb_cambus_photon_tx.sv
// Directed bench for cambus_photon_tx on a small 6x5-slot geometry with a falling-edge receiver.
`timescale 1ns/1ps
module tb_cambus_photon_tx;

  localparam int CLK_DIV    = 2;
  localparam int H_ACTIVE   = 4;
  localparam int H_BLANK    = 2;
  localparam int V_ACTIVE   = 2;
  localparam int V_BLANK    = 3;
  localparam int VSYNC_LINE = 1;
  localparam int VSYNC_LEN  = 4;
  localparam int H_TOTAL    = H_ACTIVE + H_BLANK;
  localparam int F_SLOTS    = H_TOTAL * (V_ACTIVE + V_BLANK);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        pat_en = 1'b0;
  logic        src_valid = 1'b0;
  logic [13:0] src_pixel;
  logic        src_ready, cam_DATA_CLK, cam_DATA_SYNC, cam_DATA1_OUT, cam_DATA2_OUT;
  logic        frame_start, underrun;

  int n_chk = 0;
  int n_bad = 0;

  cambus_photon_tx #(
    .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_BLANK(H_BLANK), .V_ACTIVE(V_ACTIVE),
    .V_BLANK(V_BLANK), .VSYNC_LINE(VSYNC_LINE), .VSYNC_LEN(VSYNC_LEN)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .pat_en(pat_en),
    .src_pixel(src_pixel), .src_valid(src_valid), .src_ready(src_ready),
    .cam_DATA_CLK(cam_DATA_CLK), .cam_DATA_SYNC(cam_DATA_SYNC),
    .cam_DATA1_OUT(cam_DATA1_OUT), .cam_DATA2_OUT(cam_DATA2_OUT),
    .frame_start(frame_start), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] pix_f(input int k);
    return 14'(32'h2A55 + k * 37);
  endfunction

  // Upstream source: advances to the next pixel after each src_ready pulse
  logic src_load = 1'b0;
  int   src_start = 0;
  int   src_idx = 0;
  always @(negedge clk) begin
    if (src_load)       src_idx = src_start;
    else if (src_ready) src_idx = src_idx + 1;
    src_pixel = pix_f(src_idx);
  end

  // Receiver: samples lines on DATA_CLK falling edges, counts pulses, watches line stability
  bit       qs[$], q1[$], q2[$];
  logic     mon_clr = 1'b0;
  logic     cap_on = 1'b0;
  logic     prev_dclk = 1'b0;
  logic [2:0] prev_lines = 3'b000;
  int       ready_cnt = 0, fs_cnt = 0, chg_err = 0;
  always @(negedge clk) begin
    if (mon_clr) begin
      qs.delete(); q1.delete(); q2.delete();
      ready_cnt = 0; fs_cnt = 0; chg_err = 0;
    end else if (cap_on) begin
      if (prev_dclk && !cam_DATA_CLK) begin
        qs.push_back(cam_DATA_SYNC);
        q1.push_back(cam_DATA1_OUT);
        q2.push_back(cam_DATA2_OUT);
      end
      if ({cam_DATA_SYNC, cam_DATA1_OUT, cam_DATA2_OUT} != prev_lines && !(!prev_dclk && cam_DATA_CLK))
        chg_err++;
      if (src_ready)   ready_cnt++;
      if (frame_start) fs_cnt++;
    end
    prev_dclk  = cam_DATA_CLK;
    prev_lines = {cam_DATA_SYNC, cam_DATA1_OUT, cam_DATA2_OUT};
  end

  bit          ds_vs[$], ds_hs[$];
  logic [13:0] ds_pix[$];
  logic [4:0]  ds_fix[$];
  int          n011, tail_len, tail_bad;

  task automatic decode();
    int b, sz;
    logic [6:0] lo, hi;
    bit prv;
    ds_vs.delete(); ds_hs.delete(); ds_pix.delete(); ds_fix.delete();
    sz = qs.size();
    n011 = 0;
    for (int i = 0; i + 1 < sz; i++) begin
      prv = (i == 0) ? 1'b0 : qs[i-1];
      if (!prv && qs[i] && qs[i+1]) n011++;
    end
    b = 0;
    while (b + 6 < sz && qs[b] && qs[b+1]) begin
      for (int j = 0; j < 7; j++) begin
        lo[6-j] = q1[b+j];
        hi[6-j] = q2[b+j];
      end
      ds_vs.push_back(qs[b+2]);
      ds_hs.push_back(qs[b+4]);
      ds_pix.push_back({hi, lo});
      ds_fix.push_back({qs[b], qs[b+1], qs[b+3], qs[b+5], qs[b+6]});
      b += 7;
    end
    tail_len = sz - b;
    tail_bad = 0;
    for (int i = b; i < sz; i++) if (qs[i] | q1[i] | q2[i]) tail_bad++;
  endtask

  // Expected slot stream from the frame geometry; uf_frame marks the frame whose slot 1 underran
  task automatic check_slots(input int nslots, input int uf_frame, input bit pat_mode, input int k0);
    int k, fr, r, ln, sl;
    bit ehs, evs;
    logic [13:0] epix;
    k = k0;
    check("slot_count", ds_pix.size(), nslots);
    for (int n = 0; n < nslots && n < ds_pix.size(); n++) begin
      fr  = n / F_SLOTS;
      r   = n % F_SLOTS;
      ln  = r / H_TOTAL;
      sl  = r % H_TOTAL;
      ehs = (sl < H_ACTIVE) && (ln < V_ACTIVE);
      evs = (ln == V_ACTIVE + VSYNC_LINE) && (sl < VSYNC_LEN);
      epix = '0;
      if (ehs) begin
        if (fr == uf_frame && ln == 0 && sl == 1) begin
          epix = '0;
        end else begin
          epix = pat_mode ? 14'(k) : pix_f(k);
          k++;
        end
      end
      check($sformatf("hs_%0d", n), 32'(ds_hs[n]), 32'(ehs));
      check($sformatf("vs_%0d", n), 32'(ds_vs[n]), 32'(evs));
      check($sformatf("pix_%0d", n), 32'(ds_pix[n]), 32'(epix));
      check($sformatf("fix_%0d", n), 32'(ds_fix[n]), 32'h18);
    end
  endtask

  task automatic wait_fs();
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!frame_start && c < 2000);
    if (!frame_start) check("fs_timeout", 0, 1);
  endtask

  task automatic wait_rises(input int n);
    int seen, c;
    logic last;
    seen = 0; c = 0; last = cam_DATA_CLK;
    while (seen < n && c < 500) begin
      @(posedge clk);
      #1;
      if (cam_DATA_CLK && !last) seen++;
      last = cam_DATA_CLK;
      c++;
    end
    if (seen < n) check("rise_timeout", seen, n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [31:0] w1, w2, w3;

    // Reset state
    rst = 1'b1; en = 1'b1; src_valid = 1'b1; pat_en = 1'b0;
    src_start = 0; src_load = 1'b1; mon_clr = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_dclk", 32'(cam_DATA_CLK), 0);
    check("rst_lines", 32'({cam_DATA_SYNC, cam_DATA1_OUT, cam_DATA2_OUT}), 0);
    check("rst_ready", 32'(src_ready), 0);
    check("rst_fs", 32'(frame_start), 0);
    check("rst_urun", 32'(underrun), 0);

    // Phase A: three frames, underrun in frame 2, en dropped inside frame 3
    src_load = 1'b0; mon_clr = 1'b0; rst = 1'b0; cap_on = 1'b1;
    cnt = 0;
    while (!cam_DATA_CLK && cnt < 50) begin @(negedge clk); cnt++; end
    check("first_rise", cnt, CLK_DIV);
    check("fs_first", 32'(frame_start), 1);
    cnt = 0;
    while (cam_DATA_CLK && cnt < 50)  begin @(negedge clk); cnt++; end
    while (!cam_DATA_CLK && cnt < 50) begin @(negedge clk); cnt++; end
    check("dclk_period", cnt, 2 * CLK_DIV);

    wait_fs();
    check("urun_before", 32'(underrun), 0);
    src_valid = 1'b0;
    wait_rises(7);
    @(negedge clk);
    src_valid = 1'b1;
    check("urun_set", 32'(underrun), 1);

    wait_fs();
    repeat (100) @(negedge clk);
    en = 1'b0;
    repeat (1100) @(negedge clk);
    check("urun_sticky", 32'(underrun), 1);
    cap_on = 1'b0;
    @(negedge clk);
    decode();

    w1 = 0; w2 = 0; w3 = 0;
    for (int j = 0; j < 7 && j < qs.size(); j++) begin
      w1[6-j] = qs[j];
      w2[6-j] = q1[j];
      w3[6-j] = q2[j];
    end
    check("slot0_sync", w1, 32'h64);
    check("slot0_d1", w2, 32'h55);
    check("slot0_d2", w3, 32'h54);
    check("a_sync011", n011, 3 * F_SLOTS);
    check("a_idle_lines", tail_bad, 0);
    check("a_idle_dclk", 32'(tail_len >= 50), 1);
    check("a_line_chg", chg_err, 0);
    check("a_ready_cnt", ready_cnt, 23);
    check("a_fs_cnt", fs_cnt, 3);
    check_slots(3 * F_SLOTS, 1, 1'b0, 0);

    // Phase B: restart, abort mid-slot with reset, then one frame with pat_en=1
    en = 1'b1; mon_clr = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;
    wait_fs();
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_dclk", 32'(cam_DATA_CLK), 0);
    check("mrst_lines", 32'({cam_DATA_SYNC, cam_DATA1_OUT, cam_DATA2_OUT}), 0);
    check("mrst_urun", 32'(underrun), 0);
    check("mrst_ready", 32'(src_ready), 0);
    pat_en = 1'b1; src_start = 100; src_load = 1'b1; mon_clr = 1'b1;
`ifdef CAMBUS_PHOTON_TX_PATTERN_EN
    src_valid = 1'b0;
`endif
    repeat (2) @(negedge clk);
    src_load = 1'b0; mon_clr = 1'b0; rst = 1'b0; cap_on = 1'b1;
    wait_fs();
    repeat (100) @(negedge clk);
    en = 1'b0;
    repeat (1100) @(negedge clk);
    cap_on = 1'b0;
    @(negedge clk);
    decode();
    check("b_fs_cnt", fs_cnt, 1);
    check("b_urun", 32'(underrun), 0);
    check("b_line_chg", chg_err, 0);
    check("b_sync011", n011, F_SLOTS);
`ifdef CAMBUS_PHOTON_TX_PATTERN_EN
    check("b_ready_cnt", ready_cnt, 0);
    check_slots(F_SLOTS, -1, 1'b1, 0);
`else
    check("b_ready_cnt", ready_cnt, 8);
    check_slots(F_SLOTS, -1, 1'b0, 100);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
